// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop and glitch-free reconfiguration controller for a programmable clock divider
//
// Ports:
//   clk_in      system clock
//   rst         synchronous, active-high reset
//   run         level; 1 = generate clk_out, 0 = stop at the next period boundary
//   cfg_div     requested divisor (period in clk_in cycles)
//   cfg_valid   cfg_div valid
//   cfg_ready   controller can accept a divisor
//   clk_out     divided clock, registered
//   tick        one-cycle pulse on the first clk_in cycle of each clk_out period
//   busy        1 while running
//   div_active  divisor currently in use
//   cfg_err     one-cycle pulse when a divisor < 2 is rejected
module clk_div_ctrl #(
    parameter int          CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_active,
    output logic             cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;

    logic             transfer;
    logic             div_ok;
    logic             boundary;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lo_len;

    assign transfer = cfg_valid && cfg_ready;
    assign div_ok   = (cfg_div >= CNT_W'(2));
    assign boundary = (count == div_active - CNT_W'(1));
    assign cnt_next = count + CNT_W'(1);
    // Odd divisors put the extra cycle in the low phase.
    assign lo_len   = div_active - (div_active >> 1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_ready  <= 1'b1;
            div_active <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            cfg_err <= transfer && !div_ok;
            tick    <= 1'b0;

            case (state)
                IDLE: begin
                    count   <= '0;
                    clk_out <= 1'b0;
                    busy    <= 1'b0;
                    // A divisor captured in the very cycle the block stopped
                    // has no boundary left to wait for, so take it here.
                    if (pend_valid) begin
                        div_active <= pend_div;
                        pend_valid <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (transfer && div_ok) begin
                        div_active <= cfg_div;
                    end
                    if (run) begin
                        state <= RUN;
                        tick  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (boundary) begin
                        count   <= '0;
                        clk_out <= 1'b0;
                        if (pend_valid) begin
                            div_active <= pend_div;
                            pend_valid <= 1'b0;
                            cfg_ready  <= 1'b1;
                        end
                        if (!run) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tick <= 1'b1;
                        end
                    end else begin
                        count   <= cnt_next;
                        clk_out <= (cnt_next >= lo_len);
                    end
                    // cfg_ready is low while the slot is full, so a capture
                    // never collides with the apply above; a capture on the
                    // boundary cycle therefore waits for the next boundary.
                    if (transfer && div_ok) begin
                        pend_div   <= cfg_div;
                        pend_valid <= 1'b1;
                        cfg_ready  <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
